// File: rtl/pe_dispatch_scheduler.sv
// pe_dispatch_scheduler
//   Queues instructions in a small FIFO and issues each one to a free processing
//   element, choosing free PEs round-robin. Finished PE results are collected
//   round-robin into a single registered valid/ready result port, tagged with the
//   index of the PE that produced them. Per-PE busy flags let long and short PE
//   operations overlap.
//
// Ports
//   i_clock, i_reset_n          clock (rising edge), async active-low reset
//   i_instr_valid/o_instr_ready instruction input handshake, i_instruction data
//   o_pe_issue_valid            one-hot, one-cycle issue strobe
//   o_pe_instr                  issued instruction, broadcast to all PEs
//   o_pe_busy                   per-PE busy flags
//   i_pe_done, i_pe_result      per-PE result present / result data
//   o_pe_ack                    one-hot, combinational; result taken at this edge
//   o_res_valid/i_res_ready     result output handshake, o_result / o_res_pe data
//   o_fifo_count                instruction FIFO occupancy
//   o_err_spurious              sticky: done seen on a PE that was not busy
module pe_dispatch_scheduler #(
   parameter int NUM_PE  = 4,
   parameter int INSTR_W = 12,
   parameter int RES_W   = 12,
   parameter int DEPTH   = 4,
   localparam int PE_IDX_W = $clog2(NUM_PE),
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                      i_clock,
   input  logic                      i_reset_n,
   input  logic                      i_instr_valid,
   output logic                      o_instr_ready,
   input  logic [INSTR_W-1:0]        i_instruction,
   output logic [NUM_PE-1:0]         o_pe_issue_valid,
   output logic [INSTR_W-1:0]        o_pe_instr,
   output logic [NUM_PE-1:0]         o_pe_busy,
   input  logic [NUM_PE-1:0]         i_pe_done,
   input  logic [NUM_PE*RES_W-1:0]   i_pe_result,
   output logic [NUM_PE-1:0]         o_pe_ack,
   output logic                      o_res_valid,
   input  logic                      i_res_ready,
   output logic [RES_W-1:0]          o_result,
   output logic [PE_IDX_W-1:0]       o_res_pe,
   output logic [CNT_W-1:0]          o_fifo_count,
   output logic                      o_err_spurious
);

   localparam int PTR_W = $clog2(DEPTH);

   // Round-robin pick: first requester after ptr, wrapping modulo NUM_PE.
   // Returns {found, index}.
   function automatic logic [PE_IDX_W:0] f_rr_pick(
      input logic [NUM_PE-1:0]   req,
      input logic [PE_IDX_W-1:0] ptr
   );
      logic                found;
      logic [PE_IDX_W-1:0] sel;
      logic [PE_IDX_W-1:0] idx;
      int                  j;
      found = 1'b0;
      sel   = '0;
      for (int k = 1; k <= NUM_PE; k++) begin
         j   = (int'(ptr) + k) % NUM_PE;
         idx = PE_IDX_W'(j);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
      return {found, sel};
   endfunction

   // FIFO state
   logic [INSTR_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   // Issue / busy state
   logic [NUM_PE-1:0]   r_busy;
   logic [NUM_PE-1:0]   r_issue_valid;
   logic [INSTR_W-1:0]  r_pe_instr;
   logic [PE_IDX_W-1:0] r_issue_ptr;

   // Collect state
   logic [PE_IDX_W-1:0] r_col_ptr;
   logic                r_res_valid;
   logic [RES_W-1:0]    r_result;
   logic [PE_IDX_W-1:0] r_res_pe;
   logic                r_err;

   logic                w_push;
   logic                w_pop;
   logic                w_fifo_empty;
   logic [PE_IDX_W:0]   w_issue_pick;
   logic                w_issue;
   logic [PE_IDX_W-1:0] w_issue_idx;
   logic [NUM_PE-1:0]   w_issue_oh;
   logic                w_load;
   logic [NUM_PE-1:0]   w_cand;
   logic [PE_IDX_W:0]   w_col_pick;
   logic                w_collect;
   logic [PE_IDX_W-1:0] w_col_idx;
   logic [NUM_PE-1:0]   w_ack_oh;
   logic [NUM_PE-1:0]   w_spurious;

   // Push is gated only by the registered count: a pop in the same cycle does
   // not open a slot for a write while full.
   assign o_instr_ready = (r_count < CNT_W'(DEPTH));
   assign w_push        = i_instr_valid & o_instr_ready;
   assign w_fifo_empty  = (r_count == '0);

   // Issue decision uses registered busy flags only, so a PE freed by a
   // collect this edge becomes eligible one cycle later.
   assign w_issue_pick = f_rr_pick(~r_busy, r_issue_ptr);
   assign w_issue      = !w_fifo_empty & w_issue_pick[PE_IDX_W];
   assign w_issue_idx  = w_issue_pick[PE_IDX_W-1:0];
   assign w_pop        = w_issue;

   assign w_load     = !r_res_valid | i_res_ready;
   assign w_cand     = i_pe_done & r_busy;
   assign w_col_pick = f_rr_pick(w_cand, r_col_ptr);
   assign w_collect  = w_load & w_col_pick[PE_IDX_W];
   assign w_col_idx  = w_col_pick[PE_IDX_W-1:0];
   assign w_spurious = i_pe_done & ~r_busy;

   always_comb begin
      w_issue_oh = '0;
      w_ack_oh   = '0;
      if (w_issue)
         w_issue_oh[w_issue_idx] = 1'b1;
      if (w_collect)
         w_ack_oh[w_col_idx] = 1'b1;
   end

   always_ff @(posedge i_clock) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_instruction;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_busy        <= '0;
         r_issue_valid <= '0;
         r_pe_instr    <= '0;
         r_issue_ptr   <= PE_IDX_W'(NUM_PE - 1);
      end else begin
         // Issue targets a free PE and collect a busy one, so the two never
         // touch the same bit in one cycle.
         r_busy        <= (r_busy | w_issue_oh) & ~w_ack_oh;
         r_issue_valid <= w_issue_oh;
         if (w_issue) begin
            r_pe_instr  <= r_mem[r_rd_ptr];
            r_issue_ptr <= w_issue_idx;
         end
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_col_ptr   <= PE_IDX_W'(NUM_PE - 1);
         r_res_valid <= 1'b0;
         r_result    <= '0;
         r_res_pe    <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_load) begin
            r_res_valid <= w_collect;
            if (w_collect) begin
               r_result  <= i_pe_result[w_col_idx*RES_W +: RES_W];
               r_res_pe  <= w_col_idx;
               r_col_ptr <= w_col_idx;
            end
         end
         if (|w_spurious)
            r_err <= 1'b1;
      end
   end

   assign o_pe_issue_valid = r_issue_valid;
   assign o_pe_instr       = r_pe_instr;
   assign o_pe_busy        = r_busy;
   assign o_pe_ack         = w_ack_oh;
   assign o_res_valid      = r_res_valid;
   assign o_result         = r_result;
   assign o_res_pe         = r_res_pe;
   assign o_fifo_count     = r_count;
   assign o_err_spurious   = r_err;

endmodule
